// File: rtl/sdram_tg_pkg.sv
// Shared types for the SDRAM traffic generator: FSM state encoding,
// error-counter width and a saturating add used by the read checker.
package sdram_tg_pkg;

    localparam int ERR_W = 16;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WAIT_INIT,
        ST_WR_REQ,
        ST_WR_WAIT,
        ST_WR_GAP,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_RD_GAP,
        ST_FIN
    } tg_state_e;

    // A single read cycle can add up to two errors (bad word plus bad burst length).
    function automatic logic [ERR_W-1:0] sat_add(input logic [ERR_W-1:0] a,
                                                 input logic [1:0]       inc);
        logic [ERR_W:0] sum;
        sum = {1'b0, a} + {{(ERR_W-1){1'b0}}, inc};
        return sum[ERR_W] ? {ERR_W{1'b1}} : sum[ERR_W-1:0];
    endfunction

endpackage

// File: rtl/sdram_tg_addr_gen.sv
// Column/row address counter for the traffic generator: steps by one burst,
// rolls the column over into the next row, row wraps naturally at 2^ASIZE.
module sdram_tg_addr_gen #(
    parameter int ASIZE   = 13,
    parameter int SC_BL   = 8,
    parameter int COL_MAX = 512
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             step,
    output logic [ASIZE-1:0] caddr,
    output logic [ASIZE-1:0] raddr
);

    localparam logic [ASIZE-1:0] COL_STEP = ASIZE'(SC_BL);
    localparam logic [ASIZE-1:0] COL_LAST = ASIZE'(COL_MAX - SC_BL);

    logic [ASIZE-1:0] caddr_q, caddr_d;
    logic [ASIZE-1:0] raddr_q, raddr_d;

    // Clear wins over step so a phase change never leaves a stale address.
    always_comb begin
        caddr_d = caddr_q;
        raddr_d = raddr_q;
        if (clear) begin
            caddr_d = '0;
            raddr_d = '0;
        end else if (step) begin
            if (caddr_q == COL_LAST) begin
                caddr_d = '0;
                raddr_d = raddr_q + ASIZE'(1);
            end else begin
                caddr_d = caddr_q + COL_STEP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            caddr_q <= '0;
            raddr_q <= '0;
        end else begin
            caddr_q <= caddr_d;
            raddr_q <= raddr_d;
        end
    end

    assign caddr = caddr_q;
    assign raddr = raddr_q;

endmodule

// File: rtl/sdram_traffic_gen.sv
// User-side write/read-back traffic master for sdram_control.
// Define SDRAM_TG_CHECK_EN to build the read-data checker and Err_cnt logic.
module sdram_traffic_gen
    import sdram_tg_pkg::*;
#(
    parameter int DSIZE      = 16,
    parameter int ASIZE      = 13,
    parameter int BSIZE      = 2,
    parameter int SC_BL      = 8,
    parameter int COL_MAX    = 512,
    parameter int BANK       = 2,
    parameter int NUM_BURSTS = 100,
    parameter int GAP_CYCLES = 500,
    parameter int SEED       = 0
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic             Init_done,
    output logic             Wr,
    output logic             Rd,
    output logic [ASIZE-1:0] Caddr,
    output logic [ASIZE-1:0] Raddr,
    output logic [BSIZE-1:0] Baddr,
    output logic [DSIZE-1:0] Wr_data,
    input  logic             Wr_data_vaild,
    input  logic             Wdata_done,
    input  logic [DSIZE-1:0] Rd_data,
    input  logic             Rd_data_vaild,
    input  logic             Rdata_done,
    output logic             Busy,
    output logic             Done,
    output logic             Pass,
    output logic [15:0]      Err_cnt
);

    localparam int GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int BURST_W = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
    localparam logic [DSIZE-1:0] SEED_V = DSIZE'(SEED);

    tg_state_e        state_q, state_d;
    logic             start_prev_q;
    logic             start_edge;
    logic             wr_q, wr_d;
    logic             rd_q, rd_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [DSIZE-1:0] wr_data_q, wr_data_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
    logic             addr_clear, addr_step, run_clear;
    logic             gap_last, burst_last;
    logic             check_ok;
    logic [ERR_W-1:0] err_cnt;

    assign start_edge = Start & ~start_prev_q;
    assign gap_last   = (gap_cnt_q == GAP_W'(GAP_CYCLES - 1));
    assign burst_last = (burst_cnt_q == BURST_W'(NUM_BURSTS - 1));

    sdram_tg_addr_gen #(
        .ASIZE   (ASIZE),
        .SC_BL   (SC_BL),
        .COL_MAX (COL_MAX)
    ) u_addr_gen (
        .clk   (Clk),
        .rst_n (Rst_n),
        .clear (addr_clear),
        .step  (addr_step),
        .caddr (Caddr),
        .raddr (Raddr)
    );

    always_comb begin
        state_d     = state_q;
        wr_d        = 1'b0;
        rd_d        = 1'b0;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        wr_data_d   = wr_data_q;
        gap_cnt_d   = gap_cnt_q;
        burst_cnt_d = burst_cnt_q;
        addr_clear  = 1'b0;
        addr_step   = 1'b0;
        run_clear   = 1'b0;
        case (state_q)
            ST_IDLE, ST_FIN: begin
                if (start_edge) begin
                    state_d     = ST_WAIT_INIT;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    wr_data_d   = SEED_V;
                    gap_cnt_d   = '0;
                    burst_cnt_d = '0;
                    addr_clear  = 1'b1;
                    run_clear   = 1'b1;
                end
            end
            ST_WAIT_INIT: begin
                if (Init_done) begin
                    state_d = ST_WR_REQ;
                    wr_d    = 1'b1;
                end
            end
            ST_WR_REQ: state_d = ST_WR_WAIT;
            ST_WR_WAIT: begin
                if (Wr_data_vaild) begin
                    wr_data_d = wr_data_q + DSIZE'(1);
                end
                if (Wdata_done) begin
                    state_d   = ST_WR_GAP;
                    gap_cnt_d = '0;
                end
            end
            ST_WR_GAP: begin
                gap_cnt_d = gap_cnt_q + GAP_W'(1);
                if (gap_last) begin
                    gap_cnt_d = '0;
                    if (burst_last) begin
                        burst_cnt_d = '0;
                        addr_clear  = 1'b1;
                        state_d     = ST_RD_REQ;
                        rd_d        = 1'b1;
                    end else begin
                        burst_cnt_d = burst_cnt_q + BURST_W'(1);
                        addr_step   = 1'b1;
                        state_d     = ST_WR_REQ;
                        wr_d        = 1'b1;
                    end
                end
            end
            ST_RD_REQ: state_d = ST_RD_WAIT;
            ST_RD_WAIT: begin
                if (Rdata_done) begin
                    state_d   = ST_RD_GAP;
                    gap_cnt_d = '0;
                end
            end
            ST_RD_GAP: begin
                gap_cnt_d = gap_cnt_q + GAP_W'(1);
                if (gap_last) begin
                    gap_cnt_d = '0;
                    if (burst_last) begin
                        burst_cnt_d = '0;
                        state_d     = ST_FIN;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                        pass_d      = check_ok;
                    end else begin
                        burst_cnt_d = burst_cnt_q + BURST_W'(1);
                        addr_step   = 1'b1;
                        state_d     = ST_RD_REQ;
                        rd_d        = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Edge detector resets high so a button still held through reset does not auto-start.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q      <= ST_IDLE;
            start_prev_q <= 1'b1;
            wr_q         <= 1'b0;
            rd_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            wr_data_q    <= SEED_V;
            gap_cnt_q    <= '0;
            burst_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            start_prev_q <= Start;
            wr_q         <= wr_d;
            rd_q         <= rd_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            wr_data_q    <= wr_data_d;
            gap_cnt_q    <= gap_cnt_d;
            burst_cnt_q  <= burst_cnt_d;
        end
    end

`ifdef SDRAM_TG_CHECK_EN
    localparam int WC_W = $clog2(SC_BL + 1) + 1;

    logic [DSIZE-1:0] exp_q, exp_d;
    logic [WC_W-1:0]  word_cnt_q, word_cnt_d, words_seen;
    logic [1:0]       err_inc;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    // A word arriving with Rdata_done is counted before the burst-length check.
    always_comb begin
        exp_d      = exp_q;
        word_cnt_d = word_cnt_q;
        err_cnt_d  = err_cnt_q;
        err_inc    = 2'd0;
        words_seen = word_cnt_q;
        if (run_clear) begin
            exp_d      = SEED_V;
            word_cnt_d = '0;
            err_cnt_d  = '0;
        end else if (state_q == ST_RD_REQ) begin
            word_cnt_d = '0;
        end else if (state_q == ST_RD_WAIT) begin
            if (Rd_data_vaild) begin
                exp_d = exp_q + DSIZE'(1);
                if (word_cnt_q != {WC_W{1'b1}}) begin
                    words_seen = word_cnt_q + WC_W'(1);
                end
                if (Rd_data != exp_q) begin
                    err_inc = err_inc + 2'd1;
                end
            end
            if (Rdata_done && (words_seen != WC_W'(SC_BL))) begin
                err_inc = err_inc + 2'd1;
            end
            word_cnt_d = words_seen;
            err_cnt_d  = sat_add(err_cnt_q, err_inc);
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            exp_q      <= SEED_V;
            word_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            exp_q      <= exp_d;
            word_cnt_q <= word_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign err_cnt  = err_cnt_q;
    assign check_ok = (err_cnt_q == '0);
`else
    logic unused_check;

    assign err_cnt      = '0;
    assign check_ok     = 1'b1;
    assign unused_check = ^{Rd_data, Rd_data_vaild, run_clear};
`endif

    assign Wr      = wr_q;
    assign Rd      = rd_q;
    assign Baddr   = BSIZE'(BANK);
    assign Wr_data = wr_data_q;
    assign Busy    = busy_q;
    assign Done    = done_q;
    assign Pass    = pass_q;
    assign Err_cnt = err_cnt;

endmodule

// File: tb/tb_sdram_traffic_gen.sv
// Directed bench for sdram_traffic_gen with a small behavioural SDRAM controller
// that stores written words by address and replays them on reads.
module tb_sdram_traffic_gen;

    localparam int DSIZE      = 16;
    localparam int ASIZE      = 13;
    localparam int BSIZE      = 2;
    localparam int SC_BL      = 8;
    localparam int COL_MAX    = 512;
    localparam int BANK       = 2;
    localparam int NUM_BURSTS = 100;
    localparam int GAP_CYCLES = 4;
    localparam int SEED       = 0;
    localparam int LOG_N      = 1024;
    localparam int RUN_BOUND  = 20000;
`ifdef SDRAM_TG_CHECK_EN
    localparam logic [15:0] EXP_BAD_ERR  = 16'd1;
    localparam logic        EXP_BAD_PASS = 1'b0;
`else
    localparam logic [15:0] EXP_BAD_ERR  = 16'd0;
    localparam logic        EXP_BAD_PASS = 1'b1;
`endif

    logic             Clk;
    logic             Rst_n;
    logic             Start;
    logic             Init_done;
    logic             Wr, Rd;
    logic [ASIZE-1:0] Caddr, Raddr;
    logic [BSIZE-1:0] Baddr;
    logic [DSIZE-1:0] Wr_data;
    logic             Wr_data_vaild;
    logic             Wdata_done;
    logic [DSIZE-1:0] Rd_data;
    logic             Rd_data_vaild;
    logic             Rdata_done;
    logic             Busy, Done, Pass;
    logic [15:0]      Err_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    // Monitor state
    int  cycle = 0;
    int  wr_pulses = 0, rd_pulses = 0;
    int  wr_wide = 0, rd_wide = 0, addr_unstable = 0;
    int  last_wdone_cycle = 0, last_wr_gap = 0;
    bit  wr_prev = 0, rd_prev = 0, addr_pend = 0;
    logic [ASIZE-1:0] pend_c, pend_r;
    logic [ASIZE-1:0] wr_caddr_log [0:LOG_N-1];
    logic [ASIZE-1:0] wr_raddr_log [0:LOG_N-1];

    // Controller model state
    logic [DSIZE-1:0] mem [int];
    int corrupt_key = -1;
    int short_key   = -1;

    sdram_traffic_gen #(
        .DSIZE      (DSIZE),
        .ASIZE      (ASIZE),
        .BSIZE      (BSIZE),
        .SC_BL      (SC_BL),
        .COL_MAX    (COL_MAX),
        .BANK       (BANK),
        .NUM_BURSTS (NUM_BURSTS),
        .GAP_CYCLES (GAP_CYCLES),
        .SEED       (SEED)
    ) dut (
        .Clk           (Clk),
        .Rst_n         (Rst_n),
        .Start         (Start),
        .Init_done     (Init_done),
        .Wr            (Wr),
        .Rd            (Rd),
        .Caddr         (Caddr),
        .Raddr         (Raddr),
        .Baddr         (Baddr),
        .Wr_data       (Wr_data),
        .Wr_data_vaild (Wr_data_vaild),
        .Wdata_done    (Wdata_done),
        .Rd_data       (Rd_data),
        .Rd_data_vaild (Rd_data_vaild),
        .Rdata_done    (Rdata_done),
        .Busy          (Busy),
        .Done          (Done),
        .Pass          (Pass),
        .Err_cnt       (Err_cnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Pulse width, address log, address stability and done-to-request spacing.
    always @(negedge Clk) begin
        cycle++;
        if (Wr === 1'b1) begin
            if (wr_prev) wr_wide++;
            else begin
                if (wr_pulses < LOG_N) begin
                    wr_caddr_log[wr_pulses] = Caddr;
                    wr_raddr_log[wr_pulses] = Raddr;
                end
                last_wr_gap = cycle - last_wdone_cycle;
                wr_pulses++;
                addr_pend = 1;
                pend_c = Caddr;
                pend_r = Raddr;
            end
        end
        if (Rd === 1'b1) begin
            if (rd_prev) rd_wide++;
            else begin
                rd_pulses++;
                addr_pend = 1;
                pend_c = Caddr;
                pend_r = Raddr;
            end
        end
        wr_prev = (Wr === 1'b1);
        rd_prev = (Rd === 1'b1);
        if (addr_pend && (Caddr !== pend_c || Raddr !== pend_r || Baddr !== BSIZE'(BANK)))
            addr_unstable++;
        if (Wdata_done === 1'b1 || Rdata_done === 1'b1) addr_pend = 0;
        if (Wdata_done === 1'b1) last_wdone_cycle = cycle;
    end

    // Behavioural controller: data starts the cycle after the request pulse.
    initial begin
        int key, nwords;
        logic [DSIZE-1:0] word;
        Wr_data_vaild = 1'b0;
        Wdata_done    = 1'b0;
        Rd_data       = '0;
        Rd_data_vaild = 1'b0;
        Rdata_done    = 1'b0;
        forever begin
            @(negedge Clk);
            if (Wr === 1'b1) begin
                key = int'(Raddr) * COL_MAX + int'(Caddr);
                @(posedge Clk); #1;
                for (int i = 0; i < SC_BL; i++) begin
                    Wr_data_vaild = 1'b1;
                    @(negedge Clk);
                    mem[key + i] = Wr_data;
                    @(posedge Clk); #1;
                end
                Wr_data_vaild = 1'b0;
                Wdata_done    = 1'b1;
                @(posedge Clk); #1;
                Wdata_done    = 1'b0;
            end else if (Rd === 1'b1) begin
                key    = int'(Raddr) * COL_MAX + int'(Caddr);
                nwords = (key == short_key) ? SC_BL - 1 : SC_BL;
                @(posedge Clk); #1;
                for (int i = 0; i < nwords; i++) begin
                    word = mem.exists(key + i) ? mem[key + i] : 16'hDEAD;
                    if (key + i == corrupt_key) word[0] = ~word[0];
                    Rd_data       = word;
                    Rd_data_vaild = 1'b1;
                    @(posedge Clk); #1;
                end
                Rd_data_vaild = 1'b0;
                Rdata_done    = 1'b1;
                @(posedge Clk); #1;
                Rdata_done    = 1'b0;
            end
        end
    end

    task automatic pulse_start();
        @(posedge Clk); #1 Start = 1'b1;
        @(posedge Clk); #1 Start = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        int n;
        ok = 0;
        n  = 0;
        while (!ok && n < RUN_BOUND) begin
            @(negedge Clk);
            if (Done === 1'b1) ok = 1;
            n++;
        end
    endtask

    task automatic test_reset();
        Rst_n = 1'b0; Start = 1'b0; Init_done = 1'b0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        n_checks++; if (Wr !== 1'b0) $display("[TB] FAIL reset_wr: got %b want 0", Wr); else n_pass++;
        n_checks++; if (Rd !== 1'b0) $display("[TB] FAIL reset_rd: got %b want 0", Rd); else n_pass++;
        n_checks++; if (Caddr !== 13'd0) $display("[TB] FAIL reset_caddr: got %0d want 0", Caddr); else n_pass++;
        n_checks++; if (Raddr !== 13'd0) $display("[TB] FAIL reset_raddr: got %0d want 0", Raddr); else n_pass++;
        n_checks++; if (Baddr !== 2'd2) $display("[TB] FAIL reset_baddr: got %0d want 2", Baddr); else n_pass++;
        n_checks++; if (Wr_data !== 16'd0) $display("[TB] FAIL reset_wr_data: got %0d want 0", Wr_data); else n_pass++;
        n_checks++; if (Busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", Busy); else n_pass++;
        n_checks++; if (Done !== 1'b0) $display("[TB] FAIL reset_done: got %b want 0", Done); else n_pass++;
        n_checks++; if (Pass !== 1'b0) $display("[TB] FAIL reset_pass: got %b want 0", Pass); else n_pass++;
        n_checks++; if (Err_cnt !== 16'd0) $display("[TB] FAIL reset_err_cnt: got %0d want 0", Err_cnt); else n_pass++;
        @(posedge Clk); #1 Rst_n = 1'b1;
        repeat (2) @(posedge Clk);
    endtask

    // Start edge with Init_done low for 300 cycles, then a nominal run with a Start edge mid-run.
    task automatic test_nominal_run();
        int  w0, r0;
        bit  ok;
        w0 = wr_pulses;
        r0 = rd_pulses;
        @(posedge Clk); #1 Start = 1'b1;
        @(negedge Clk);
        n_checks++; if (Busy !== 1'b0) $display("[TB] FAIL busy_edge_cycle: got %b want 0", Busy); else n_pass++;
        @(posedge Clk); #1 Start = 1'b0;
        @(negedge Clk);
        n_checks++; if (Busy !== 1'b1) $display("[TB] FAIL busy_after_edge: got %b want 1", Busy); else n_pass++;
        repeat (300) @(posedge Clk);
        n_checks++; if (wr_pulses != w0) $display("[TB] FAIL wr_before_init: got %0d pulses want 0", wr_pulses - w0); else n_pass++;
        #1 Init_done = 1'b1;
        @(negedge Clk);
        n_checks++; if (Wr !== 1'b0) $display("[TB] FAIL wr_init_same_cycle: got %b want 0", Wr); else n_pass++;
        @(negedge Clk);
        n_checks++; if (Wr !== 1'b1) $display("[TB] FAIL wr_init_next_cycle: got %b want 1", Wr); else n_pass++;
        @(negedge Clk);
        n_checks++; if (Wr !== 1'b0) $display("[TB] FAIL wr_one_cycle: got %b want 0", Wr); else n_pass++;
        pulse_start();
        wait_done(ok);
        n_checks++; if (!ok) $display("[TB] FAIL nominal_timeout: got no Done want Done within %0d cycles", RUN_BOUND); else n_pass++;
        n_checks++; if (Busy !== 1'b0) $display("[TB] FAIL nominal_busy: got %b want 0", Busy); else n_pass++;
        n_checks++; if (Pass !== 1'b1) $display("[TB] FAIL nominal_pass: got %b want 1", Pass); else n_pass++;
        n_checks++; if (Err_cnt !== 16'd0) $display("[TB] FAIL nominal_err_cnt: got %0d want 0", Err_cnt); else n_pass++;
        n_checks++; if (Wr_data !== 16'd800) $display("[TB] FAIL nominal_wr_data: got %0d want 800", Wr_data); else n_pass++;
        n_checks++; if (wr_pulses - w0 != 100) $display("[TB] FAIL nominal_wr_count: got %0d want 100", wr_pulses - w0); else n_pass++;
        n_checks++; if (rd_pulses - r0 != 100) $display("[TB] FAIL nominal_rd_count: got %0d want 100", rd_pulses - r0); else n_pass++;
        n_checks++; if (wr_caddr_log[w0 + 63] !== 13'd504 || wr_raddr_log[w0 + 63] !== 13'd0)
            $display("[TB] FAIL row_end_addr: got c=%0d r=%0d want c=504 r=0", wr_caddr_log[w0 + 63], wr_raddr_log[w0 + 63]);
        else n_pass++;
        n_checks++; if (wr_caddr_log[w0 + 64] !== 13'd0 || wr_raddr_log[w0 + 64] !== 13'd1)
            $display("[TB] FAIL row_wrap_addr: got c=%0d r=%0d want c=0 r=1", wr_caddr_log[w0 + 64], wr_raddr_log[w0 + 64]);
        else n_pass++;
        n_checks++; if (last_wr_gap != GAP_CYCLES + 1) $display("[TB] FAIL burst_gap: got %0d want %0d", last_wr_gap, GAP_CYCLES + 1); else n_pass++;
        n_checks++; if (wr_wide != 0 || rd_wide != 0) $display("[TB] FAIL pulse_width: got wr=%0d rd=%0d long pulses want 0", wr_wide, rd_wide); else n_pass++;
        n_checks++; if (addr_unstable != 0) $display("[TB] FAIL addr_stable: got %0d changes want 0", addr_unstable); else n_pass++;
        repeat (50) @(negedge Clk);
        n_checks++; if (Done !== 1'b1) $display("[TB] FAIL done_hold: got %b want 1", Done); else n_pass++;
    endtask

    task automatic test_corrupted_read();
        int r0;
        bit ok;
        r0 = rd_pulses;
        corrupt_key = 5;
        @(posedge Clk); #1 Start = 1'b1;
        @(posedge Clk); #1 Start = 1'b0;
        @(negedge Clk);
        n_checks++; if (Done !== 1'b0 || Busy !== 1'b1) $display("[TB] FAIL restart_flags: got done=%b busy=%b want 0 1", Done, Busy); else n_pass++;
        @(negedge Clk);
        n_checks++; if (Wr !== 1'b1) $display("[TB] FAIL init_ready_wr: got %b want 1", Wr); else n_pass++;
        wait_done(ok);
        n_checks++; if (!ok) $display("[TB] FAIL corrupt_timeout: got no Done want Done within %0d cycles", RUN_BOUND); else n_pass++;
        n_checks++; if (Err_cnt !== EXP_BAD_ERR) $display("[TB] FAIL corrupt_err_cnt: got %0d want %0d", Err_cnt, EXP_BAD_ERR); else n_pass++;
        n_checks++; if (Pass !== EXP_BAD_PASS) $display("[TB] FAIL corrupt_pass: got %b want %b", Pass, EXP_BAD_PASS); else n_pass++;
        n_checks++; if (rd_pulses - r0 != 100) $display("[TB] FAIL corrupt_rd_count: got %0d want 100", rd_pulses - r0); else n_pass++;
        corrupt_key = -1;
    endtask

    task automatic test_short_burst();
        bit ok;
        short_key = (NUM_BURSTS - 1) * SC_BL;
        pulse_start();
        wait_done(ok);
        n_checks++; if (!ok) $display("[TB] FAIL short_timeout: got no Done want Done within %0d cycles", RUN_BOUND); else n_pass++;
        n_checks++; if (Err_cnt !== EXP_BAD_ERR) $display("[TB] FAIL short_err_cnt: got %0d want %0d", Err_cnt, EXP_BAD_ERR); else n_pass++;
        n_checks++; if (Pass !== EXP_BAD_PASS) $display("[TB] FAIL short_pass: got %b want %b", Pass, EXP_BAD_PASS); else n_pass++;
        short_key = -1;
    endtask

    task automatic test_reset_mid_run();
        int w0, n;
        bit ok;
        w0 = wr_pulses;
        pulse_start();
        n = 0;
        while (wr_pulses == w0 && n < 50) begin
            @(negedge Clk);
            n++;
        end
        n_checks++; if (wr_pulses == w0) $display("[TB] FAIL midrun_first_wr: got no Wr want Wr within 50 cycles"); else n_pass++;
        repeat (3) @(negedge Clk);
        @(posedge Clk); #1 Rst_n = 1'b0;
        @(posedge Clk); #1 Rst_n = 1'b1;
        @(negedge Clk);
        n_checks++; if (Wr_data !== 16'd0) $display("[TB] FAIL midrun_wr_data: got %0d want 0", Wr_data); else n_pass++;
        n_checks++; if (Busy !== 1'b0 || Done !== 1'b0 || Pass !== 1'b0) $display("[TB] FAIL midrun_flags: got busy=%b done=%b pass=%b want 0 0 0", Busy, Done, Pass); else n_pass++;
        n_checks++; if (Wr !== 1'b0 || Rd !== 1'b0 || Caddr !== 13'd0 || Raddr !== 13'd0) $display("[TB] FAIL midrun_req_addr: got wr=%b rd=%b c=%0d r=%0d want 0 0 0 0", Wr, Rd, Caddr, Raddr); else n_pass++;
        w0 = wr_pulses;
        repeat (20) @(negedge Clk);
        n_checks++; if (Busy !== 1'b0 || wr_pulses != w0 || Wr_data !== 16'd0) $display("[TB] FAIL midrun_idle: got busy=%b pulses=%0d wr_data=%0d want 0 0 0", Busy, wr_pulses - w0, Wr_data); else n_pass++;
        pulse_start();
        wait_done(ok);
        n_checks++; if (!ok) $display("[TB] FAIL replay_timeout: got no Done want Done within %0d cycles", RUN_BOUND); else n_pass++;
        n_checks++; if (wr_caddr_log[w0] !== 13'd0 || wr_raddr_log[w0] !== 13'd0) $display("[TB] FAIL replay_first_addr: got c=%0d r=%0d want 0 0", wr_caddr_log[w0], wr_raddr_log[w0]); else n_pass++;
        n_checks++; if (wr_pulses - w0 != 100) $display("[TB] FAIL replay_wr_count: got %0d want 100", wr_pulses - w0); else n_pass++;
        n_checks++; if (Pass !== 1'b1 || Err_cnt !== 16'd0) $display("[TB] FAIL replay_result: got pass=%b err=%0d want 1 0", Pass, Err_cnt); else n_pass++;
        n_checks++; if (Wr_data !== 16'd800) $display("[TB] FAIL replay_wr_data: got %0d want 800", Wr_data); else n_pass++;
    endtask

    initial begin
        Rst_n     = 1'b0;
        Start     = 1'b0;
        Init_done = 1'b0;
        test_reset();
        test_nominal_run();
        test_corrupted_read();
        test_short_burst();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
